// File: rtl/data_memory.sv
// Word-addressed data memory: asynchronous read, synchronous write and clear.
// Out-of-range addresses are write-ignored and read as zero.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  in_range;
    logic                  wr_en_d;
    logic [IDX_W-1:0]      idx;
    // Declaration initializer gives defined zero contents before any reset edge.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    assign in_range = ({1'b0, addr} < DEPTH_EXT);
    assign idx      = addr[IDX_W-1:0];
    assign wr_en_d  = we & in_range;
    assign q        = in_range ? mem_q[idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            mem_q[idx] <= data;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboarded bench for data_memory: directed boundary cases plus random traffic
// against an array-based reference of the memory contents.
`timescale 1ns / 100ps
module tb_data_memory;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] q;

    data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .data (data),
        .q    (q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] exp;
        logic [AW-1:0] a;
        string         name;
    } item_t;

    item_t       sb_q[$];
    int          req_cnt  = 0;
    int          done_cnt = 0;
    int          tests    = 0;
    int          fails    = 0;
    logic [DW-1:0] ref_mem [DEPTH];

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (a < DEPTH) return ref_mem[a[6:0]];
        return '0;
    endfunction

    // Behaviour of one rising edge given the inputs present at that edge.
    task automatic ref_edge();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else if (we && addr < DEPTH) begin
            ref_mem[addr[6:0]] = data;
        end
    endtask

    task automatic check(input string name);
        item_t it;
        it.exp  = ref_read(addr);
        it.a    = addr;
        it.name = name;
        sb_q.push_back(it);
        req_cnt++;
        for (int k = 0; k < 5 && done_cnt != req_cnt; k++) #0.1;
        if (done_cnt != req_cnt) begin
            tests++;
            fails++;
            $display("FAIL %s: monitor timeout (served %0d of %0d)", name, done_cnt, req_cnt);
            done_cnt = req_cnt;
        end
    endtask

    // Monitor: compares the DUT read port against each queued expectation.
    initial begin
        item_t it;
        forever begin
            wait (req_cnt != done_cnt);
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                tests++;
                if (q !== it.exp) begin
                    fails++;
                    $display("FAIL %s: addr=%0h q=%0h expected=%0h", it.name, it.a, q, it.exp);
                end
            end
            done_cnt++;
        end
    end

    task automatic edge_and_check(input string name);
        @(posedge clk);
        ref_edge();
        #1;
        check(name);
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        rst  = r;
        we   = w;
        addr = a;
        data = d;
        #1;
    endtask

    initial begin
        int r;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rst  = 1'b1;
        we   = 1'b0;
        addr = 77;
        data = '0;
        #1 rst = 1'b0;
        #1 check("powerup_q0");

        drive(1'b0, 1'b1, 77, 45);
        check("rdw_old_value");
        edge_and_check("write_77_45");

        drive(1'b0, 1'b0, 77, 35);
        edge_and_check("we0_hold_1");
        edge_and_check("we0_hold_2");

        @(negedge clk);
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check("rst_glitch_between_edges");
        edge_and_check("rst_glitch_no_effect");

        drive(1'b0, 1'b1, 200, 99);
        edge_and_check("oor_write_reads0");
        drive(1'b0, 1'b0, 72, 0);
        check("oor_no_alias_72");

        drive(1'b0, 1'b1, 32'h8000_004D, 32'hCAFE_F00D);
        edge_and_check("oor_highbit_reads0");
        drive(1'b0, 1'b0, 77, 0);
        check("oor_highbit_no_alias_77");

        drive(1'b1, 1'b1, 77, 7);
        edge_and_check("rst_beats_write");
        drive(1'b0, 1'b0, 0, 0);
        for (int a = 0; a < DEPTH; a++) begin
            addr = a;
            #0.1;
            check("after_rst_sweep");
            @(negedge clk);
        end

        drive(1'b0, 1'b1, 0, 32'hDEAD_BEEF);
        edge_and_check("wr_addr0");
        drive(1'b0, 1'b1, 127, 32'h1234_5678);
        edge_and_check("wr_addr127");
        drive(1'b0, 1'b0, 0, 0);
        check("rd_addr0");
        addr = 1;   #0.2 check("rd_addr1_zero");
        addr = 126; #0.2 check("rd_addr126_zero");
        addr = 127; #0.2 check("rd_addr127");

        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] a;
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = $urandom_range(128, 300);
            else if (r < 6)  a = $urandom_range(0, 15);
            else             a = $urandom_range(0, 127);
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), a, $urandom);
            check("rand_pre_edge");
            edge_and_check("rand_post_edge");
            addr = $urandom_range(0, 15);
            #0.2 check("rand_read");
        end

        drive(1'b0, 1'b0, 0, 0);
        for (int a = 0; a < DEPTH; a++) begin
            addr = a;
            #0.1;
            check("final_sweep");
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the width of the addr port.
REQ-003 Parameter DEPTH, default 128, SHALL set the number of stored words.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 we  input  1  write enable; 1 writes data on the rising edge, 0 leaves storage unchanged.
REQ-008 addr  input  ADDR_WIDTH  word address; word-addressed, not byte-addressed.
REQ-009 data  input  DATA_WIDTH  write data.
REQ-010 q  output  DATA_WIDTH  read data.

Function
REQ-011 Storage SHALL be an array of DEPTH words of DATA_WIDTH bits, indexed directly by addr (addr N selects word N).
REQ-012 Reads SHALL be asynchronous: q = word[addr] combinationally, with no clock latency.
REQ-013 On a rising clk edge with rst=0, we=1 and addr<DEPTH, word[addr] SHALL take the value of data.
REQ-014 The written value SHALL appear on q in the same cycle, immediately after that edge, while addr is held.
REQ-015 With we=0, no word SHALL change regardless of data or addr.
REQ-016 An addr>=DEPTH SHALL be out of range.
REQ-017 An out-of-range write SHALL be ignored, with no aliasing onto in-range words.
REQ-018 An out-of-range read SHALL return q=0.
REQ-019 Only the addressed word SHALL change on a write; all other words hold their values.
REQ-020 Read-during-write to the same address SHALL show the old value before the edge and the new value after it.
REQ-021 DEPTH SHALL be supported at any value from 1 to 2^ADDR_WIDTH.
REQ-022 The comparison addr<DEPTH SHALL use the full addr width.
REQ-023 q SHALL be free of X: all words hold defined values at all times.

Reset
REQ-024 On a rising clk edge with rst=1, every word SHALL be cleared to 0.
REQ-025 Reset SHALL take priority over a simultaneous write, so the write is discarded.
REQ-026 Reset SHALL be synchronous only: asserting and releasing rst between clock edges has no effect on storage.
REQ-027 All words SHALL also be 0 at power-up/simulation start, so q=0 before any write even if no reset edge occurred.
REQ-028 After reset, q SHALL read 0 for every address.
REQ-029 Reset asserted mid-operation SHALL clear previously written words at the next rising edge.

Verification
REQ-030 Power-up, rst=1 for 1 ns then 0 before the first edge, addr=77, we=0 -> q=0.
REQ-031 we=1, addr=77, data=45, one rising edge -> q=45 after the edge.
REQ-032 Then we=0, data=35, addr=77, one or more edges -> q stays 45.
REQ-033 we=1, addr=200, data=99, one edge -> q=0 at addr=200, and addr=72 (200 mod 128) still reads its prior value, 0.
REQ-034 Word 77=45, then rst=1 and we=1 with data=7 at addr=77 for one edge -> q=0 at 77, and every address reads 0.
REQ-035 Write 0xDEADBEEF at addr=0 and 0x12345678 at addr=127 -> each reads back correctly, and addr=1 and addr=126 read 0.
